// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED SPI link controller.
package oled_pkg;

    // Link sequencing states
    typedef enum logic [2:0] {
        StRstLow,
        StRstWait,
        StInitSend,
        StArb,
        StXfer
    } link_state_e;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    localparam int unsigned INIT_LEN = 8;

    // Panel init command list, streamed once after the hardware reset pulse
    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
        8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hAF
    };

endpackage

// File: rtl/oled_spi_byte_tx.sv
// SPI mode-0 byte shifter: MSB first, CLK_DIV system clocks per half-period.
// A byte occupies exactly 16*CLK_DIV clocks starting the cycle after load;
// done pulses in the final clock so a new load can follow without a gap.
module oled_spi_byte_tx #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] tx_byte,
    output logic       oled_clk,
    output logic       oled_mosi,
    output logic       done
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             busy_q, busy_d;
    logic             high_q, high_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             phase_end;

    assign phase_end = (div_q == DIV_LAST);

    // Shifter state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q  <= 1'b0;
            high_q  <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            busy_q  <= busy_d;
            high_q  <= high_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    // Phase/bit sequencing; load takes priority so back-to-back bytes chain seamlessly
    always_comb begin
        busy_d  = busy_q;
        high_d  = high_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        if (load) begin
            busy_d  = 1'b1;
            high_d  = 1'b0;
            div_d   = '0;
            bit_d   = '0;
            shreg_d = tx_byte;
        end else if (busy_q) begin
            if (phase_end) begin
                div_d = '0;
                if (high_q) begin
                    // End of high phase: next bit goes out as the clock falls
                    high_d  = 1'b0;
                    shreg_d = {shreg_q[6:0], 1'b0};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        busy_d = 1'b0;
                    end
                end else begin
                    high_d = 1'b1;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // Pin and completion outputs; both pins rest low when idle
    always_comb begin
        oled_clk  = busy_q & high_q;
        oled_mosi = busy_q & shreg_q[7];
        done      = busy_q & high_q & phase_end & (bit_q == 3'd7);
    end

endmodule

// File: rtl/oled_link_ctrl.sv
// OLED SPI link controller: panel reset pulse, init list, then byte-wise
// arbitration between the command port (dc=0) and the pixel port (dc=1).
// Build option: define OLED_PIX_BURST_EN to lock arbitration onto the pixel
// port from the first granted pixel byte until one tagged pix_last is sent.
module oled_link_ctrl
    import oled_pkg::*;
#(
    parameter int unsigned CLK_DIV         = 2,
    parameter int unsigned RST_LOW_CYCLES  = 16,
    parameter int unsigned RST_WAIT_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
    input  logic       pix_last,
    output logic       pix_ready,
    output logic       init_done,
    output logic       oled_clk,
    output logic       oled_mosi,
    output logic       oled_dc,
    output logic       oled_cs_n,
    output logic       oled_rst_n
);

    localparam int unsigned CNT_MAX = (RST_LOW_CYCLES > RST_WAIT_CYCLES) ?
                                      RST_LOW_CYCLES : RST_WAIT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = $clog2(INIT_LEN);
    localparam logic [CNT_W-1:0] RST_LOW_LAST  = CNT_W'(RST_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_WAIT_LAST = CNT_W'(RST_WAIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(INIT_LEN - 1);

    link_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
    logic             dc_q, dc_d;
    logic             init_done_q, init_done_d;
    logic             grant_cmd, grant_pix;
    logic             tx_load, tx_done;
    logic [7:0]       tx_byte;

`ifdef OLED_PIX_BURST_EN
    logic             lock_q, lock_d;
`else
    logic             unused_pix_last;
    assign unused_pix_last = pix_last;
`endif

    assign idx_nxt   = idx_q + 1'b1;
    assign oled_dc   = dc_q;
    assign init_done = init_done_q;

    oled_spi_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (tx_load),
        .tx_byte   (tx_byte),
        .oled_clk  (oled_clk),
        .oled_mosi (oled_mosi),
        .done      (tx_done)
    );

    // State register and sequencing counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StRstLow;
            cnt_q       <= '0;
            idx_q       <= '0;
            dc_q        <= DC_CMD;
            init_done_q <= 1'b0;
`ifdef OLED_PIX_BURST_EN
            lock_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            dc_q        <= dc_d;
            init_done_q <= init_done_d;
`ifdef OLED_PIX_BURST_EN
            lock_q      <= lock_d;
`endif
        end
    end

    // Arbitration decode: command wins unless a pixel burst holds the lock
    always_comb begin
        grant_cmd = 1'b0;
        grant_pix = 1'b0;
        if (state_q == StArb) begin
`ifdef OLED_PIX_BURST_EN
            grant_cmd = cmd_valid & ~lock_q;
`else
            grant_cmd = cmd_valid;
`endif
            grant_pix = pix_valid & ~grant_cmd;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        dc_d        = dc_q;
        init_done_d = init_done_q;
`ifdef OLED_PIX_BURST_EN
        lock_d      = lock_q;
`endif
        case (state_q)
            StRstLow: begin
                if (cnt_q == RST_LOW_LAST) begin
                    state_d = StRstWait;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRstWait: begin
                if (cnt_q == RST_WAIT_LAST) begin
                    state_d = StInitSend;
                    cnt_d   = '0;
                    idx_d   = '0;
                    dc_d    = DC_CMD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StInitSend: begin
                if (tx_done) begin
                    if (idx_q == IDX_LAST) begin
                        state_d     = StArb;
                        init_done_d = 1'b1;
                    end else begin
                        idx_d = idx_nxt;
                    end
                end
            end
            StArb: begin
                if (grant_cmd) begin
                    state_d = StXfer;
                    dc_d    = DC_CMD;
                end else if (grant_pix) begin
                    state_d = StXfer;
                    dc_d    = DC_DATA;
`ifdef OLED_PIX_BURST_EN
                    // Lock stays set until the byte tagged last has been granted
                    lock_d  = ~pix_last;
`endif
                end
            end
            StXfer: begin
                if (tx_done) begin
                    state_d = StArb;
                end
            end
            default: state_d = StRstLow;
        endcase
    end

    // Output decode: pins, handshakes and shifter load
    always_comb begin
        oled_rst_n = 1'b1;
        oled_cs_n  = 1'b1;
        cmd_ready  = 1'b0;
        pix_ready  = 1'b0;
        tx_load    = 1'b0;
        tx_byte    = INIT_ROM[0];
        case (state_q)
            StRstLow: oled_rst_n = 1'b0;
            StRstWait: begin
                // First init byte is loaded on the last wait clock
                tx_load = (cnt_q == RST_WAIT_LAST);
            end
            StInitSend: begin
                oled_cs_n = 1'b0;
                if (tx_done && idx_q != IDX_LAST) begin
                    tx_load = 1'b1;
                    tx_byte = INIT_ROM[idx_nxt];
                end
            end
            StArb: begin
                cmd_ready = grant_cmd;
                pix_ready = grant_pix;
                oled_cs_n = ~(grant_cmd | grant_pix);
                tx_load   = grant_cmd | grant_pix;
                tx_byte   = grant_cmd ? cmd_data : pix_data;
            end
            StXfer: oled_cs_n = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: doc/oled_link_ctrl.md
Name: oled_link_ctrl

Overview:
- Sequences and shares the OLED SPI link, which comprises the pins oled_clk, oled_mosi, oled_dc, oled_cs_n and oled_rst_n.
- After reset it drives the panel hardware-reset pulse, then streams a fixed init command list.
- It then arbitrates byte-by-byte between two requesters: a command port (dc=0) from game logic and a pixel port (dc=1) from the frame renderer.
- It sits between the game/render logic and the top-level io_out pins.

Parameters:
- CLK_DIV, 2: system clocks per SPI clock half-period (≥1).
- RST_LOW_CYCLES, 16: clocks oled_rst_n is held low after reset release.
- RST_WAIT_CYCLES, 16: clocks to wait after oled_rst_n rises, before the first init byte.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command byte offered
- cmd_data  in  8  command byte
- cmd_ready  out  1  command byte accepted this cycle
- pix_valid  in  1  pixel byte offered
- pix_data  in  8  pixel byte
- pix_last  in  1  marks last byte of a pixel burst (used only with the optional feature)
- pix_ready  out  1  pixel byte accepted this cycle
- init_done  out  1  init sequence complete; sticky until reset
- oled_clk  out  1  SPI clock, idle low
- oled_mosi  out  1  SPI data, MSB first
- oled_dc  out  1  0 = command, 1 = data
- oled_cs_n  out  1  chip select, active low
- oled_rst_n  out  1  panel reset, active low

Behaviour:
- Reset values (asynchronous, apply immediately on reset_n low, including mid-byte):
  - oled_clk=0, oled_mosi=0, oled_dc=0, oled_cs_n=1, oled_rst_n=0
  - cmd_ready=0, pix_ready=0, init_done=0
  - All counters cleared.
- States: RST_LOW → RST_WAIT → INIT_SEND → ARB ⇄ XFER.
- RST_LOW:
  - oled_rst_n=0 for RST_LOW_CYCLES clocks after reset_n rises.
  - Then oled_rst_n=1 for the rest of operation.
- RST_WAIT: count RST_WAIT_CYCLES clocks, then go to INIT_SEND.
- INIT_SEND:
  - Send INIT_ROM[0..INIT_LEN-1] in order, dc=0, cs_n held low across all init bytes.
  - After the last byte: cs_n=1, init_done=1, go to ARB.
  - cmd_ready and pix_ready stay 0 throughout init.
- ARB (exactly one cycle per decision):
  - If cmd_valid: cmd_ready=1, latch cmd_data, dc=0.
  - Else if pix_valid: pix_ready=1, latch pix_data, dc=1.
  - Command always wins a simultaneous request.
  - If no request: cs_n=1, stay in ARB.
  - ready is combinational from valid in ARB only; never asserted in any other state.
- XFER, entered at cycle T+1 after acceptance at T:
  - cs_n=0 and dc stable for the whole byte.
  - Each bit: CLK_DIV clocks with oled_clk=0 (mosi updated at the start of the low phase), then CLK_DIV clocks with oled_clk=1. SPI mode 0.
  - Bit order 7..0.
  - Byte length is exactly 16*CLK_DIV clocks; then return to ARB.
- Chip select between bytes:
  - Back-to-back accepted bytes keep cs_n low through the ARB cycle.
  - cs_n rises only in an ARB cycle with no grant.
- Throughput: one byte per 16*CLK_DIV+1 clocks.
- oled_mosi returns to 0 in ARB.
- Input data is latched at acceptance; input changes during XFER have no effect.

Optional Feature:
- Macro: OLED_PIX_BURST_EN.
- Defined:
  - Once a pixel byte is granted, ARB grants only pixel requests (ignores cmd_valid) until a byte accepted with pix_last=1 has finished.
  - If pix_valid is low mid-burst, the link idles (cs_n=1) and the lock is held.
  - Reset clears the lock.
- Undefined: pix_last is ignored; per-byte command priority applies.

Decomposition:
- Package oled_pkg:
  - State enum.
  - DC_CMD=1'b0, DC_DATA=1'b1.
  - INIT_LEN=8.
  - INIT_ROM constant array {8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hAF}.
- Sub-module oled_spi_byte_tx:
  - Inputs: load, byte.
  - Outputs: oled_clk, oled_mosi, done (pulse in the final clock of the byte).
  - Owns the bit counter and the CLK_DIV phase counter.
  - The controller owns state, dc, cs_n, rst_n and arbitration.

Test Plan (CLK_DIV=2, RST_LOW_CYCLES=16, RST_WAIT_CYCLES=16):
- Release reset_n:
  - oled_rst_n low exactly 16 clocks, then high; 16 clocks later cs_n falls.
  - 8 bytes AE,A0,72,A1,00,A2,00,AF are shifted MSB-first with dc=0, 32 clocks each.
  - init_done rises after the last byte; ready stays 0 throughout.
- After init, cmd_valid with cmd_data=8'hA5:
  - cmd_ready pulses 1 cycle.
  - mosi sampled on oled_clk rising edges reads 1,0,1,0,0,1,0,1, with dc=0.
  - cs_n rises on the ARB cycle when cmd_valid is low.
- cmd_valid and pix_valid asserted together, cmd=8'h15, pix=8'hF0:
  - 8'h15 is sent first (dc=0), then 8'hF0 (dc=1).
  - cs_n stays low between the two bytes; the gap between bytes is exactly 1 ARB clock.
- reset_n pulsed low mid-byte during pixel transfer:
  - All outputs take reset values in the same cycle.
  - Full reset/init sequence repeats after release.
- With OLED_PIX_BURST_EN, 4 pixel bytes (last on the 4th) with cmd_valid asserted after byte 1:
  - All 4 pixel bytes are sent before the command.
  - Without the macro, the command is sent after byte 1.
